uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx.sv | 99 +++++++++
 rtl/uart_tx.sv | 127 ++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, state encodings and helpers.
// Imported by uart_tx and uart_rx; no ports.
package uart_pkg;

    localparam int   CPB_DEFAULT = 4;
    localparam int   DATA_BITS   = 8;
    localparam logic LINE_START  = 1'b0;
    localparam logic LINE_STOP   = 1'b1;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Width of a down-counter holding 0..n-1, never below 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver used as the loopback partner of uart_tx.
// Ports: clk, rst (async high), SER_TX line in, out_data/out_valid pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = CPB_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SER_TX,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid
);

    localparam int CW = cnt_width(clocks_per_bit);
    localparam logic [CW-1:0] CYC_LAST = CW'(clocks_per_bit - 1);
    // Start edge is seen one cycle late, so aim one short of mid-bit.
    localparam logic [CW-1:0] HALF_M1  = CW'(clocks_per_bit / 2 - 1);
    localparam logic [2:0]    NBIT_LAST = 3'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           nbit, nbit_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [DATA_BITS-1:0] dq, dq_n;
    logic                 vq, vq_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
            cnt   <= '0;
            nbit  <= '0;
            sh    <= '0;
            dq    <= '0;
            vq    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            nbit  <= nbit_n;
            sh    <= sh_n;
            dq    <= dq_n;
            vq    <= vq_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        nbit_n  = nbit;
        sh_n    = sh;
        dq_n    = dq;
        vq_n    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (SER_TX == LINE_START) begin
                    state_n = RX_START;
                    cnt_n   = HALF_M1;
                end
            end
            RX_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else if (SER_TX == LINE_START) begin
                    state_n = RX_DATA;
                    cnt_n   = CYC_LAST;
                    nbit_n  = '0;
                end else begin
                    state_n = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    cnt_n = CYC_LAST;
                    sh_n  = {SER_TX, sh[DATA_BITS-1:1]};
                    if (nbit == NBIT_LAST) state_n = RX_STOP;
                    else nbit_n = nbit + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    state_n = RX_IDLE;
                    if (SER_TX == LINE_STOP) begin
                        vq_n = 1'b1;
                        dq_n = sh;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end

    assign out_data  = dq;
    assign out_valid = vq;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one shifter plus a one-entry holding register.
// Ports: clk, rst (async high), in_data/in_valid/in_ready handshake,
//        SER_TX serial line (idle high), out_idle (fully drained).
module uart_tx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit  = CPB_DEFAULT,
    parameter int extra_stop_bits = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 SER_TX,
    output logic                 out_idle
);

    localparam int CW = cnt_width(clocks_per_bit);
    localparam logic [CW-1:0] CYC_LAST = CW'(clocks_per_bit - 1);
    // Bit index 0 is start, 1..8 data, the rest stop bits.
    localparam logic [4:0] BIT_LAST =
        5'(DATA_BITS + 1 + extra_stop_bits);
    localparam logic [4:0] BIT_DATA_END = 5'(DATA_BITS);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [CW-1:0]        cyc, cyc_n;
    logic [4:0]           bitc, bit_n;
    logic                 ser, ser_n;
    logic [DATA_BITS-1:0] hold, hold_n;
    logic                 hv, hv_n;
    logic                 rdy, rdy_n;
    logic                 accept;
    logic                 load;
    logic [DATA_BITS-1:0] load_byte;

    assign accept = in_valid && rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TX_IDLE;
            shreg <= '0;
            cyc   <= '0;
            bitc  <= '0;
            ser   <= LINE_STOP;
            hold  <= '0;
            hv    <= 1'b0;
            rdy   <= 1'b1;
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            cyc   <= cyc_n;
            bitc  <= bit_n;
            ser   <= ser_n;
            hold  <= hold_n;
            hv    <= hv_n;
            rdy   <= rdy_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        cyc_n     = cyc;
        bit_n     = bitc;
        ser_n     = ser;
        hold_n    = hold;
        hv_n      = hv;
        load      = 1'b0;
        load_byte = in_data;
        unique case (state)
            TX_IDLE: begin
                if (accept) load = 1'b1;
            end
            TX_BUSY: begin
                if (cyc != '0) begin
                    cyc_n = cyc - CW'(1);
                    if (accept) begin
                        hold_n = in_data;
                        hv_n   = 1'b1;
                    end
                end else if (bitc == BIT_LAST) begin
                    // Frame ends: chain the next byte with no gap.
                    if (hv) begin
                        load      = 1'b1;
                        load_byte = hold;
                        hv_n      = 1'b0;
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_n = TX_IDLE;
                        ser_n   = LINE_STOP;
                    end
                end else begin
                    cyc_n = CYC_LAST;
                    bit_n = bitc + 5'd1;
                    if (bitc < BIT_DATA_END) begin
                        ser_n   = shreg[0];
                        shreg_n = {1'b0, shreg[DATA_BITS-1:1]};
                    end else begin
                        ser_n = LINE_STOP;
                    end
                    if (accept) begin
                        hold_n = in_data;
                        hv_n   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (load) begin
            state_n = TX_BUSY;
            shreg_n = load_byte;
            cyc_n   = CYC_LAST;
            bit_n   = '0;
            ser_n   = LINE_START;
        end
        rdy_n = !hv_n;
    end

    assign in_ready = rdy;
    assign SER_TX   = ser;
    assign out_idle = (state == TX_IDLE) && !hv
                   && (ser == LINE_STOP);

endmodule

// File: tb/tb_uart_tx.sv
// Loopback bench: four uart_tx/uart_rx pairs at different bit rates.
// Directed frame table, hand sequences and a random stream check.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid [4];
    logic [7:0] in_data  [4];
    logic       in_ready [4];
    logic       ser      [4];
    logic       idle     [4];
    logic       rxv      [4];
    logic [7:0] rxd      [4];
    logic [7:0] rxq [4][$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : ch
        localparam int CPB = (g == 0) ? 4 : (g == 1) ? 2
                           : (g == 2) ? 7 : 3;
        localparam int XS  = (g == 3) ? 2 : 0;
        uart_tx #(
            .clocks_per_bit (CPB),
            .extra_stop_bits(XS)
        ) u_tx (
            .clk     (clk),
            .rst     (rst),
            .in_data (in_data[g]),
            .in_valid(in_valid[g]),
            .in_ready(in_ready[g]),
            .SER_TX  (ser[g]),
            .out_idle(idle[g])
        );
        uart_rx #(
            .clocks_per_bit(CPB)
        ) u_rx (
            .clk      (clk),
            .rst      (rst),
            .SER_TX   (ser[g]),
            .out_data (rxd[g]),
            .out_valid(rxv[g])
        );
        always @(posedge clk)
            if (rxv[g]) rxq[g].push_back(rxd[g]);
    end

    typedef struct {
        int         ch;
        int         cpb;
        int         nbits;
        logic [7:0] data;
        logic [12:0] line;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_valid[c] = 1'b1;
        in_data[c]  = d;
        while (!in_ready[c] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid[c] = 1'b0;
    endtask

    task automatic wait_idle(input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!idle[c] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_rx(input int c, input string name,
                             input logic [7:0] d);
        if (rxq[c].size() == 0) chk(name, 32'hffff, {24'h0, d});
        else chk(name, {24'h0, rxq[c].pop_front()}, {24'h0, d});
    endtask

    initial begin
        logic [7:0] sent [$];
        int zeros;
        int chans [3];

        vt[0] = '{0, 4, 10, 8'h55, 13'b111_1010101010};
        vt[1] = '{0, 4, 10, 8'hA5, 13'b111_1101001010};
        vt[2] = '{3, 3, 12, 8'h81, 13'b1111100000010};
        vt[3] = '{1, 2, 10, 8'h00, 13'b111_1000000000};
        vt[4] = '{2, 7, 10, 8'hFF, 13'b111_1111111110};
        vt[5] = '{0, 4, 10, 8'h3C, 13'b111_1001111000};

        for (int c = 0; c < 4; c++) begin
            in_valid[c] = 1'b0;
            in_data[c]  = 8'h00;
        end
        rst = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("rst_line",  {31'h0, ser[c]},      1);
            chk("rst_ready", {31'h0, in_ready[c]}, 1);
            chk("rst_idle",  {31'h0, idle[c]},     1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames.
        for (int i = 0; i < 6; i++) begin
            int c;
            int len;
            c   = vt[i].ch;
            len = vt[i].nbits * vt[i].cpb;
            @(negedge clk);
            chk("pre_line", {31'h0, ser[c]}, 1);
            in_valid[c] = 1'b1;
            in_data[c]  = vt[i].data;
            @(posedge clk);
            #1 in_valid[c] = 1'b0;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_k%0d", i, k), {31'h0, ser[c]},
                    {31'h0, vt[i].line[k / vt[i].cpb]});
                if (k == len - 1)
                    chk("busy_idle", {31'h0, idle[c]}, 0);
            end
            @(negedge clk);
            chk("post_line", {31'h0, ser[c]},  1);
            chk("post_idle", {31'h0, idle[c]}, 1);
            wait_idle(c);
            expect_rx(c, $sformatf("v%0d_rx", i), vt[i].data);
            chk("v_rx_extra", rxq[c].size(), 0);
        end

        // Back-to-back with in_valid held: 40-cycle start spacing.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h00;
        @(posedge clk);
        #1 in_data[0] = 8'hFF;
        @(negedge clk);
        chk("b2b_rdy_k0", {31'h0, in_ready[0]}, 1);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_rdy_k1", {31'h0, in_ready[0]}, 0);
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (k == 39) chk("b2b_stop", {31'h0, ser[0]}, 1);
            if (k == 40) begin
                chk("b2b_start", {31'h0, ser[0]}, 0);
                chk("b2b_rdy_k40", {31'h0, in_ready[0]}, 1);
            end
        end
        wait_idle(0);
        expect_rx(0, "b2b_rx0", 8'h00);
        expect_rx(0, "b2b_rx1", 8'hFF);

        // Third byte stalls until the held byte moves.
        push(0, 8'h11);
        push(0, 8'h22);
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'h33;
        zeros = 0;
        while (!in_ready[0] && zeros < 200) begin
            zeros++;
            @(negedge clk);
        end
        chk("hold_stall", zeros, 39);
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        wait_idle(0);
        expect_rx(0, "three_rx0", 8'h11);
        expect_rx(0, "three_rx1", 8'h22);
        expect_rx(0, "three_rx2", 8'h33);
        chk("three_extra", rxq[0].size(), 0);

        // Reset during data bit 3, held byte discarded.
        push(0, 8'h00);
        push(0, 8'h77);
        repeat (17) @(negedge clk);
        chk("mid_line", {31'h0, ser[0]}, 0);
        chk("mid_ready", {31'h0, in_ready[0]}, 0);
        #1 rst = 1'b1;
        #1;
        chk("abort_line",  {31'h0, ser[0]},      1);
        chk("abort_ready", {31'h0, in_ready[0]}, 1);
        chk("abort_idle",  {31'h0, idle[0]},     1);
        in_valid[0] = 1'b1;
        in_data[0]  = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_hold_line", {31'h0, ser[0]}, 1);
        rst = 1'b0;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        chk("rel_start", {31'h0, ser[0]}, 0);
        wait_idle(0);
        expect_rx(0, "after_rst_rx", 8'hA5);
        chk("after_rst_extra", rxq[0].size(), 0);

        // Random streams at cpb 2, 4 and 7.
        chans = '{1, 0, 2};
        for (int j = 0; j < 3; j++) begin
            int c;
            c = chans[j];
            sent.delete();
            for (int n = 0; n < 20; n++) begin
                logic [7:0] d;
                d = 8'($urandom);
                repeat ($urandom_range(0, 12)) @(negedge clk);
                push(c, d);
                sent.push_back(d);
            end
            wait_idle(c);
            chk($sformatf("rand%0d_cnt", c), rxq[c].size(),
                sent.size());
            while (sent.size() > 0 && rxq[c].size() > 0)
                chk($sformatf("rand%0d_byte", c),
                    {24'h0, rxq[c].pop_front()},
                    {24'h0, sent.pop_front()});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
